// File: rtl/shade_dispatch_pkg.sv
// shade_dispatch_pkg
// Shared graphics definitions for the triangle dispatcher and the shader unit:
//   state_t      dispatcher FSM states (also exported on the debug port)
//   FETCH_WORDS  words per triangle in the vertex buffer (3 vertices x xyz)
//   vec3_t       float32 x,y,z vertex as an unpacked array of three words
package shade_dispatch_pkg;

   localparam int FETCH_WORDS = 9;

   typedef logic [31:0] vec3_t [3];

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_LAUNCH    = 3'd2,
      ST_WAIT_BUSY = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_WRITE     = 3'd5,
      ST_FINISH    = 3'd6
   } state_t;

endpackage

// File: rtl/shade_dispatch_if.sv
// shade_dispatch_if
// Bundles the three memory/shader-facing buses of the dispatcher:
//   vertex RAM read : vmem_rd, vmem_addr (out), vmem_data (in, one cycle after vmem_rd)
//   shader          : sh_start, sh_p1..sh_p3 (out), sh_done, sh_color (in)
//   color RAM write : cmem_we, cmem_addr, cmem_data (out)
// master = dispatcher side, slave = RAM/shader side.
interface shade_dispatch_if #(
   parameter int ADDR_W = 16
);
   import shade_dispatch_pkg::*;

   logic              vmem_rd;
   logic [ADDR_W-1:0] vmem_addr;
   logic [31:0]       vmem_data;

   logic              sh_start;
   vec3_t             sh_p1;
   vec3_t             sh_p2;
   vec3_t             sh_p3;
   logic              sh_done;
   logic [3:0]        sh_color;

   logic              cmem_we;
   logic [ADDR_W-1:0] cmem_addr;
   logic [3:0]        cmem_data;

   modport master (
      output vmem_rd, vmem_addr,
      input  vmem_data,
      output sh_start, sh_p1, sh_p2, sh_p3,
      input  sh_done, sh_color,
      output cmem_we, cmem_addr, cmem_data
   );

   modport slave (
      input  vmem_rd, vmem_addr,
      output vmem_data,
      input  sh_start, sh_p1, sh_p2, sh_p3,
      output sh_done, sh_color,
      input  cmem_we, cmem_addr, cmem_data
   );

endinterface

// File: rtl/shade_dispatch_vertex_fetch.sv
// shade_dispatch_vertex_fetch
// Nine-word vertex read sequencer with capture registers.
//   clk, sreset  clock, synchronous active-high reset
//   req          held high by the FSM for the whole FETCH phase
//   base         word address of the triangle's first word
//   rd, addr     vertex RAM read strobe/address (addr is 0 when rd is low)
//   rdata        vertex RAM data, valid the cycle after rd
//   ack          high in the last FETCH cycle, when the final word is captured
//   p1, p2, p3   captured vertices, held until the next fetch overwrites them
// Cycle k (0..8) of a request reads base+k; cycle 9 only captures word 8.
module shade_dispatch_vertex_fetch
   import shade_dispatch_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              sreset,
   input  logic              req,
   input  logic [ADDR_W-1:0] base,
   output logic              rd,
   output logic [ADDR_W-1:0] addr,
   input  logic [31:0]       rdata,
   output logic              ack,
   output vec3_t             p1,
   output vec3_t             p2,
   output vec3_t             p3
);

   localparam int CNT_W = 4;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cap_idx;
   logic             cap_en;
   logic [31:0]      words [FETCH_WORDS];

   assign rd   = req && (cnt < CNT_W'(FETCH_WORDS));
   assign addr = rd ? (base + ADDR_W'(cnt)) : '0;
   assign ack  = req && (cnt == CNT_W'(FETCH_WORDS));

   // The read is registered along with its slot so the word returned one
   // cycle later lands in the right holding register.
   always_ff @(posedge clk) begin
      if (sreset) begin
         cnt     <= '0;
         cap_en  <= 1'b0;
         cap_idx <= '0;
         for (int k = 0; k < FETCH_WORDS; k++) words[k] <= '0;
      end else begin
         cnt     <= (req && !ack) ? cnt + 1'b1 : '0;
         cap_en  <= rd;
         cap_idx <= cnt;
         if (cap_en) words[cap_idx] <= rdata;
      end
   end

   always_comb begin
      for (int j = 0; j < 3; j++) begin
         p1[j] = words[j];
         p2[j] = words[3 + j];
         p3[j] = words[6 + j];
      end
   end

endmodule

// File: rtl/shade_dispatch.sv
// shade_dispatch
// Walks a vertex buffer, loads each triangle into the shader's vertex
// registers, launches the shader and writes the returned color per triangle.
//   clk, sreset          clock, synchronous active-high reset
//   go                   start a batch (only looked at in IDLE)
//   vbase, cbase         vertex / color buffer base word addresses (latched on go)
//   tri_count            triangles in the batch (latched on go)
//   busy                 high whenever the FSM is not IDLE
//   finished             one-cycle end-of-batch pulse (normal or aborted)
//   error                sticky shader timeout flag, cleared by the next go
//   dbg_state            current FSM state
//   bus                  vertex RAM, shader and color RAM buses (master side)
//
// Handshakes: the FSM raises fetch req and holds it until the fetcher returns
// ack for one cycle; the shader is launched by a single-cycle sh_start, is
// considered to have accepted the job once sh_done drops, and its sh_color is
// taken on the first cycle sh_done is high again.
module shade_dispatch
   import shade_dispatch_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              sreset,
   input  logic              go,
   input  logic [ADDR_W-1:0] vbase,
   input  logic [ADDR_W-1:0] cbase,
   input  logic [15:0]       tri_count,
   output logic              busy,
   output logic              finished,
   output logic              error,
   output state_t            dbg_state,
   shade_dispatch_if.master  bus
);

   localparam int WCNT_W = $clog2(TIMEOUT) + 1;

   state_t            state, state_n;
   logic [15:0]       idx;
   logic [15:0]       cnt_r;
   logic [ADDR_W-1:0] vptr;
   logic [ADDR_W-1:0] cptr;
   logic [3:0]        color_r;
   logic              error_r;
   logic              finished_r;
   logic [WCNT_W-1:0] wait_cnt;
   logic              timeout_hit;

   logic              fetch_rd;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_ack;
   vec3_t             p1, p2, p3;

   shade_dispatch_vertex_fetch #(.ADDR_W(ADDR_W)) u_fetch (
      .clk    (clk),
      .sreset (sreset),
      .req    (state == ST_FETCH),
      .base   (vptr),
      .rd     (fetch_rd),
      .addr   (fetch_addr),
      .rdata  (bus.vmem_data),
      .ack    (fetch_ack),
      .p1     (p1),
      .p2     (p2),
      .p3     (p3)
   );

   assign bus.vmem_rd   = fetch_rd;
   assign bus.vmem_addr = fetch_addr;
   assign bus.sh_p1     = p1;
   assign bus.sh_p2     = p2;
   assign bus.sh_p3     = p3;

   assign timeout_hit = (wait_cnt == WCNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (sreset) state <= ST_IDLE;
      else        state <= state_n;
   end

   // Next state
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:      if (go) state_n = (tri_count == 16'd0) ? ST_FINISH : ST_FETCH;
         ST_FETCH:     if (fetch_ack) state_n = ST_LAUNCH;
         ST_LAUNCH:    state_n = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (!bus.sh_done)    state_n = ST_WAIT_DONE;
            else if (timeout_hit) state_n = ST_FINISH;
         end
         ST_WAIT_DONE: begin
            if (bus.sh_done)     state_n = ST_WRITE;
            else if (timeout_hit) state_n = ST_FINISH;
         end
         ST_WRITE:     state_n = ((idx + 16'd1) == cnt_r) ? ST_FINISH : ST_FETCH;
         ST_FINISH:    state_n = ST_IDLE;
         default:      state_n = ST_IDLE;
      endcase
   end

   // Batch datapath. Pointers advance by whole triangles so no multiplier is
   // needed; address sums wrap at 2^ADDR_W.
   always_ff @(posedge clk) begin
      if (sreset) begin
         idx        <= '0;
         cnt_r      <= '0;
         vptr       <= '0;
         cptr       <= '0;
         color_r    <= '0;
         error_r    <= 1'b0;
         finished_r <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         // Registered off FINISH: the pulse shows up in the cycle the FSM is
         // back in IDLE, i.e. two cycles after a zero-count go.
         finished_r <= (state == ST_FINISH);
         case (state)
            ST_IDLE: begin
               if (go) begin
                  vptr    <= vbase;
                  cptr    <= cbase;
                  cnt_r   <= tri_count;
                  idx     <= '0;
                  error_r <= 1'b0;
               end
            end
            ST_LAUNCH: wait_cnt <= '0;
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (state == ST_WAIT_DONE && bus.sh_done) color_r <= bus.sh_color;
               // Only the timeout path leaves a wait state for FINISH.
               if (state_n == ST_FINISH) error_r <= 1'b1;
            end
            ST_WRITE: begin
               idx  <= idx + 16'd1;
               vptr <= vptr + ADDR_W'(FETCH_WORDS);
               cptr <= cptr + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      busy          = (state != ST_IDLE);
      bus.sh_start  = (state == ST_LAUNCH);
      bus.cmem_we   = 1'b0;
      bus.cmem_addr = '0;
      bus.cmem_data = '0;
      if (state == ST_WRITE) begin
         bus.cmem_we   = 1'b1;
         bus.cmem_addr = cptr;
         bus.cmem_data = color_r;
      end
   end

   assign finished  = finished_r;
   assign error     = error_r;
   assign dbg_state = state;

endmodule

// File: tb/tb_shade_dispatch.sv
// tb_shade_dispatch
// Random and directed batches against a reference model that derives, from
// the batch parameters and a per-triangle shader plan, the read address list,
// the vertex words expected at each launch, the color writes and the final
// error flag. A monitor pops those expectations as the DUT produces events.
module tb_shade_dispatch;
   import shade_dispatch_pkg::*;

   localparam int ADDR_W   = 16;
   localparam int TIMEOUT  = 64;
   localparam int HANG_LAT = 150;

   logic        clk;
   logic        sreset;
   logic        go;
   logic [15:0] vbase;
   logic [15:0] cbase;
   logic [15:0] tri_count;
   logic        busy;
   logic        finished;
   logic        error;
   state_t      dbg_state;

   shade_dispatch_if #(.ADDR_W(ADDR_W)) bus ();

   shade_dispatch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .sreset    (sreset),
      .go        (go),
      .vbase     (vbase),
      .cbase     (cbase),
      .tri_count (tri_count),
      .busy      (busy),
      .finished  (finished),
      .error     (error),
      .dbg_state (dbg_state),
      .bus       (bus)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard state ----------------
   int           total = 0;
   int           bad   = 0;
   logic [15:0]  exp_rd_q[$];
   logic [287:0] exp_start_q[$];
   logic [19:0]  exp_wr_q[$];
   logic         exp_fin_q[$];
   int           plan_lat_q[$];
   int           plan_pre_q[$];
   logic [3:0]   plan_col_q[$];
   logic [31:0]  vram [65536];

   task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_event(input string name);
      total++;
      bad++;
      $display("FAIL %s: got unexpected event expected none", name);
   endtask

   function automatic logic [287:0] sh_pack();
      return {bus.sh_p1[0], bus.sh_p1[1], bus.sh_p1[2],
              bus.sh_p2[0], bus.sh_p2[1], bus.sh_p2[2],
              bus.sh_p3[0], bus.sh_p3[1], bus.sh_p3[2]};
   endfunction

   // ---------------- vertex RAM model ----------------
   always @(posedge clk) begin
      if (bus.vmem_rd) bus.vmem_data <= vram[bus.vmem_addr];
   end

   // ---------------- shader model ----------------
   initial begin : shader_model
      int lat;
      int pre;
      logic [3:0] col;
      bus.sh_done  = 1'b1;
      bus.sh_color = 4'h0;
      forever begin
         @(negedge clk);
         if (bus.sh_start === 1'b1 && sreset === 1'b0) begin
            if (plan_lat_q.size() == 0) begin
               fail_event("sh_start_unplanned");
            end else begin
               lat = plan_lat_q.pop_front();
               pre = plan_pre_q.pop_front();
               col = plan_col_q.pop_front();
               repeat (pre) @(negedge clk);
               bus.sh_color = ~col;
               bus.sh_done  = 1'b0;
               repeat (lat) @(negedge clk);
               bus.sh_color = col;
               bus.sh_done  = 1'b1;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (sreset === 1'b0) begin
            if (bus.vmem_rd) begin
               if (exp_rd_q.size() == 0) fail_event("vmem_rd_extra");
               else check("vmem_addr", bus.vmem_addr, exp_rd_q.pop_front());
            end
            if (bus.sh_start) begin
               if (exp_start_q.size() == 0) fail_event("sh_start_extra");
               else check("sh_p_at_start", sh_pack(), exp_start_q.pop_front());
            end
            if (bus.cmem_we) begin
               if (exp_wr_q.size() == 0) fail_event("cmem_we_extra");
               else check("cmem_write", {bus.cmem_addr, bus.cmem_data}, exp_wr_q.pop_front());
            end
            if (finished) begin
               if (exp_fin_q.size() == 0) fail_event("finished_extra");
               else begin
                  check("error_at_finish", error, exp_fin_q.pop_front());
                  check("busy_at_finish", busy, 1'b0);
               end
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // Triangle t occupies words vb+9t .. vb+9t+8 (mod 2^16) and writes its
   // color to cb+t. A hung triangle is fetched and launched but never written,
   // and ends the batch with error set.
   task automatic plan_batch(input logic [15:0] vb, input logic [15:0] cb, input int n,
                             input int hang_idx, input int lat_fix, input int col_fix,
                             input bit no_tail);
      logic err;
      err = 1'b0;
      for (int t = 0; t < n; t++) begin
         int           first;
         int           lat;
         logic [3:0]   col;
         logic [287:0] pk;
         first = (int'(vb) + 9 * t) % 65536;
         pk = '0;
         for (int k = 0; k < FETCH_WORDS; k++) begin
            exp_rd_q.push_back(16'((first + k) % 65536));
            pk = {pk[255:0], vram[(first + k) % 65536]};
         end
         exp_start_q.push_back(pk);
         if (t == hang_idx) begin
            plan_lat_q.push_back(HANG_LAT);
            plan_pre_q.push_back(0);
            plan_col_q.push_back(4'h0);
            err = 1'b1;
            break;
         end
         lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 40));
         col = (col_fix >= 0) ? 4'(col_fix) : 4'($urandom_range(0, 15));
         plan_lat_q.push_back(lat);
         plan_pre_q.push_back(int'($urandom_range(0, 3)));
         plan_col_q.push_back(col);
         if (!no_tail) exp_wr_q.push_back({16'((int'(cb) + t) % 65536), col});
      end
      if (!no_tail) exp_fin_q.push_back(err);
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_finished();
      int c;
      c = 0;
      while (finished !== 1'b1 && c < 5000) begin
         @(negedge clk);
         c++;
      end
      if (finished !== 1'b1) fail_event("finished_timeout");
   endtask

   task automatic wait_shader_idle();
      int c;
      c = 0;
      while ((bus.sh_done !== 1'b1 || plan_lat_q.size() != 0) && c < 400) begin
         @(negedge clk);
         c++;
      end
      if (bus.sh_done !== 1'b1 || plan_lat_q.size() != 0) fail_event("shader_idle_timeout");
   endtask

   task automatic issue_go(input logic [15:0] vb, input logic [15:0] cb, input int n);
      @(negedge clk);
      go        = 1'b1;
      vbase     = vb;
      cbase     = cb;
      tri_count = 16'(n);
      @(negedge clk);
      go        = 1'b0;
      vbase     = 16'($urandom);
      cbase     = 16'($urandom);
      tri_count = 16'($urandom);
   endtask

   task automatic run_batch(input logic [15:0] vb, input logic [15:0] cb, input int n,
                            input int hang_idx, input int lat_fix, input int col_fix);
      plan_batch(vb, cb, n, hang_idx, lat_fix, col_fix, 1'b0);
      issue_go(vb, cb, n);
      check("busy_after_go", busy, 1'b1);
      check("error_cleared_by_go", error, 1'b0);
      check("first_vmem_rd", bus.vmem_rd, n > 0);
      if (n == 0) begin
         check("finished_zero_early", finished, 1'b0);
         @(negedge clk);
         check("finished_zero_latency", finished, 1'b1);
      end else begin
         // go while busy must be ignored
         go = 1'b1;
         repeat (3) @(negedge clk);
         go = 1'b0;
         wait_finished();
      end
      wait_shader_idle();
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_finished"}, finished, 1'b0);
      check({tag, "_error"}, error, 1'b0);
      check({tag, "_vmem"}, {bus.vmem_rd, bus.vmem_addr}, '0);
      check({tag, "_sh_start"}, bus.sh_start, 1'b0);
      check({tag, "_sh_p"}, sh_pack(), '0);
      check({tag, "_cmem"}, {bus.cmem_we, bus.cmem_addr, bus.cmem_data}, '0);
      check({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int          c;
      int          n;
      int          hang;
      logic [15:0] vb;
      logic [15:0] cb;
      for (int a = 0; a < 65536; a++) vram[a] = $urandom;
      go        = 1'b0;
      vbase     = '0;
      cbase     = '0;
      tri_count = '0;
      sreset    = 1'b1;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      sreset = 1'b0;

      // one triangle, color A after 40 cycles
      run_batch(16'h0040, 16'h2000, 1, -1, 40, 10);
      check("error_after_ok", error, 1'b0);

      // three triangles from 0x100
      run_batch(16'h0100, 16'h3000, 3, -1, 0, -1);

      // empty batch
      run_batch(16'h0500, 16'h3100, 0, -1, 0, -1);

      // shader never completes: abort with error, no writes
      run_batch(16'h0200, 16'h3200, 2, 0, 0, -1);
      check("error_sticky", error, 1'b1);

      // next go clears error
      run_batch(16'h0300, 16'h3300, 2, -1, 0, -1);
      check("error_after_recover", error, 1'b0);

      // vertex and color addresses wrap
      run_batch(16'hFFFC, 16'hFFFF, 2, -1, 0, -1);

      // reset while waiting on the shader
      plan_batch(16'h0700, 16'h3700, 1, -1, 30, 5, 1'b1);
      issue_go(16'h0700, 16'h3700, 1);
      c = 0;
      while (dbg_state != ST_WAIT_DONE && c < 200) begin
         @(negedge clk);
         c++;
      end
      if (dbg_state != ST_WAIT_DONE) fail_event("reach_wait_done_timeout");
      repeat (4) @(negedge clk);
      sreset = 1'b1;
      @(negedge clk);
      check_quiet("mid_reset");
      sreset = 1'b0;
      wait_shader_idle();
      repeat (3) @(negedge clk);
      check("no_finish_after_reset", finished, 1'b0);

      // new batch after the reset
      run_batch(16'h0800, 16'h3800, 2, -1, 0, -1);

      // random batches
      for (int b = 0; b < 8; b++) begin
         n    = int'($urandom_range(0, 4));
         vb   = ($urandom_range(0, 2) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
         cb   = 16'($urandom);
         hang = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n)) : -1;
         run_batch(vb, cb, n, hang, 0, -1);
      end

      repeat (5) @(negedge clk);
      check("reads_outstanding", exp_rd_q.size(), 0);
      check("starts_outstanding", exp_start_q.size(), 0);
      check("writes_outstanding", exp_wr_q.size(), 0);
      check("finishes_outstanding", exp_fin_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
